// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle multiply/divide unit that owns HI/LO.
// mult/multu/div/divu occupy the unit for a fixed number of cycles.
// mthi/mtlo complete in a single cycle. Requests that arrive while the unit
// is busy are dropped.
module mdu_iterative #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state;
  mdu_op_e     op_q;
  logic [3:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;

  // Result path: evaluated from the latched operands and consumed on the last RUN edge.
  logic [63:0]        result;
  logic               result_wr;
  logic signed [63:0] sa64;
  logic signed [63:0] sb64;
  logic signed [31:0] sa32;
  logic signed [31:0] sdiv;
  logic [31:0]        udiv;

  assign sa64 = {{32{a_q[31]}}, a_q};
  assign sb64 = {{32{b_q[31]}}, b_q};
  assign sa32 = a_q;
  // A zero divisor never writes HI/LO; substituting 1 keeps the divider free of X.
  assign sdiv = (b_q == 32'd0) ? 32'sd1 : b_q;
  assign udiv = (b_q == 32'd0) ? 32'd1 : b_q;

  // Product/quotient selection for the pending op.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    result    = '0;
    result_wr = 1'b0;
    unique case (op_q)
      OP_MULT: begin
        result    = sa64 * sb64;
        result_wr = 1'b1;
      end
      OP_MULTU: begin
        result    = {32'd0, a_q} * {32'd0, b_q};
        result_wr = 1'b1;
      end
      OP_DIV: begin
        result_wr = (b_q != 32'd0);
        if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
          // Quotient overflows 32 bits; the architected result wraps to the dividend.
          result = {32'd0, 32'h8000_0000};
        end else begin
          result = {32'(sa32 % sdiv), 32'(sa32 / sdiv)};
        end
      end
      OP_DIVU: begin
        result_wr = (b_q != 32'd0);
        result    = {a_q % udiv, a_q / udiv};
      end
      default: begin
        result    = '0;
        result_wr = 1'b0;
      end
    endcase
  end

  // Control FSM, operand latches and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses nonblocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state <= ST_IDLE;
      op_q  <= OP_NONE;
      cnt   <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (Start) begin
            unique case (mdu_op_e'(MDUOp))
              OP_MULT, OP_MULTU: begin
                op_q  <= mdu_op_e'(MDUOp);
                a_q   <= SrcA;
                b_q   <= SrcB;
                cnt   <= 4'(MULT_CYCLES);
                state <= ST_RUN;
                Busy  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                op_q  <= mdu_op_e'(MDUOp);
                a_q   <= SrcA;
                b_q   <= SrcB;
                cnt   <= 4'(DIV_CYCLES);
                state <= ST_RUN;
                Busy  <= 1'b1;
              end
              OP_MTHI: HI <= SrcA;
              OP_MTLO: LO <= SrcA;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            op_q  <= OP_NONE;
            if (result_wr) begin
              HI <= result[63:32];
              LO <= result[31:0];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
